// File: rtl/seg_scan_controller_if.sv
// Display-side bundle of the 4-digit seven-segment scan controller:
// digit data and controls in, multiplexed anode/segment drive out.
interface seg_scan_controller_if;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [2:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_done;

  modport master (
    output digits, dp_in, digit_en, brightness,
    input  an, seg, dp, digit_idx, frame_done
  );

  modport slave (
    input  digits, dp_in, digit_en, brightness,
    output an, seg, dp, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed 4-digit seven-segment driver with anti-ghost blanking,
// per-digit enables, decimal points and 8-level PWM brightness.
module seg_scan_controller #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  seg_scan_controller_if.slave bus
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  // Slot counter restarts at 0, so the phase after reset follows BLANK_CYC.
  localparam state_e RST_STATE = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic [2:0]       pwm_cnt_q, pwm_cnt_d;
  logic [15:0]      digits_sh_q, digits_sh_d;
  logic [3:0]       dp_sh_q, dp_sh_d;
  logic [3:0]       en_sh_q, en_sh_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;
  logic             slot_wrap;
  logic             lit;
  logic [3:0]       cur_nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic in_blank(input logic [CNT_W-1:0] cnt);
    return 32'(cnt) < BLANK_CYC;
  endfunction

  // Slot/PWM counters and once-per-slot shadow capture.
  always_comb begin
    slot_wrap   = (slot_cnt_q == CNT_MAX);
    slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
    digit_idx_d = digit_idx_q + 2'(slot_wrap);
    pwm_cnt_d   = pwm_cnt_q + 3'd1;
    digits_sh_d = digits_sh_q;
    dp_sh_d     = dp_sh_q;
    en_sh_d     = en_sh_q;
    if (slot_cnt_q == '0) begin
      digits_sh_d = bus.digits;
      dp_sh_d     = bus.dp_in;
      en_sh_d     = bus.digit_en;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RST_STATE;
    else       state_q <= state_d;
  end

  // FSM next state: tracks the blank/show phase of the upcoming slot count.
  always_comb begin
    state_d = state_q;
    state_d = in_blank(slot_cnt_d) ? ST_BLANK : ST_SHOW;
  end

  // FSM outputs: drive the selected digit only when shown, enabled and PWM-on.
  always_comb begin
    an_d         = 4'hF;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    frame_done_d = slot_wrap && (digit_idx_q == 2'd3);
    cur_nibble   = digits_sh_q[{digit_idx_q, 2'b00} +: 4];
    lit          = (state_q == ST_SHOW) && en_sh_q[digit_idx_q] &&
                   (pwm_cnt_q <= bus.brightness);
    if (lit) begin
      an_d  = ~(4'b0001 << digit_idx_q);
      seg_d = hex_to_seg(cur_nibble);
      dp_d  = ~dp_sh_q[digit_idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q   <= '0;
      digit_idx_q  <= 2'd0;
      pwm_cnt_q    <= 3'd0;
      digits_sh_q  <= 16'h0000;
      dp_sh_q      <= 4'h0;
      en_sh_q      <= 4'h0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_idx_q  <= digit_idx_d;
      pwm_cnt_q    <= pwm_cnt_d;
      digits_sh_q  <= digits_sh_d;
      dp_sh_q      <= dp_sh_d;
      en_sh_q      <= en_sh_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;
  assign bus.digit_idx  = digit_idx_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller: cycle-level scoreboard against a
// time-based reference model, plus per-frame directed checks and a TICK_DIV=2 instance.
module tb_seg_scan_controller;

  localparam int unsigned TD = 16;
  localparam int unsigned BC = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic [1:0] idx;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  logic reset2;

  always #5 clk = ~clk;

  seg_scan_controller_if bus ();
  seg_scan_controller_if bus2 ();

  seg_scan_controller #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  seg_scan_controller #(.TICK_DIV(2), .BLANK_CYC(0)) dut_edge (
    .clk(clk), .reset(reset2), .bus(bus2)
  );

  int errors = 0;
  int checks = 0;

  obs_t exp_q[$];

  // Reference model state: cycles since reset release plus captured shadows.
  int         m_t;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  m_en;

  // Per-run statistics gathered from observed outputs.
  int         k;
  int         lit_cnt[4];
  int         dp_low[4];
  logic [6:0] seg_seen[4];
  int         fd_cnt;
  int         fd_at;
  int         multi_an;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // Predict the outputs that follow the next rising edge from current inputs.
  task automatic model_push();
    obs_t e;
    int   sc, di, pw;
    logic on;
    e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0, idx: 2'd0};
    if (reset) begin
      m_t   = 0;
      m_dig = 16'h0;
      m_dp  = 4'h0;
      m_en  = 4'h0;
    end else begin
      sc = m_t % TD;
      di = (m_t / TD) % 4;
      pw = m_t % 8;
      on = (sc >= BC) && m_en[di] && (pw <= int'(bus.brightness));
      if (on) begin
        e.an  = ~(4'b0001 << di);
        e.seg = hex7(m_dig[di*4 +: 4]);
        e.dp  = ~m_dp[di];
      end
      e.fd = (sc == TD - 1) && (di == 3);
      if (sc == 0) begin
        m_dig = bus.digits;
        m_dp  = bus.dp_in;
        m_en  = bus.digit_en;
      end
      m_t++;
      e.idx = 2'((m_t / TD) % 4);
    end
    exp_q.push_back(e);
  endtask

  task automatic clear_stats();
    k = 0; fd_cnt = 0; fd_at = -1; multi_an = 0;
    for (int i = 0; i < 4; i++) begin
      lit_cnt[i] = 0; dp_low[i] = 0; seg_seen[i] = 7'h7F;
    end
  endtask

  // One clock: push expectation, let the edge happen, compare on the falling edge.
  task automatic cyc();
    obs_t o, e;
    logic [3:0] sel;
    model_push();
    @(negedge clk);
    o = {bus.an, bus.seg, bus.dp, bus.frame_done, bus.digit_idx};
    e = exp_q.pop_front();
    chk("scan", 32'(o), 32'(e));
    k++;
    for (int i = 0; i < 4; i++) begin
      sel = ~(4'b0001 << i);
      if (o.an == sel) begin
        lit_cnt[i]++;
        seg_seen[i] = o.seg;
        if (!o.dp) dp_low[i]++;
      end
    end
    if ($countones(~o.an) > 1) multi_an++;
    if (o.fd) begin
      fd_cnt++;
      if (fd_at < 0) fd_at = k;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cyc();
    chk("rst_an", 32'(bus.an), 32'(4'hF));
    chk("rst_seg", 32'(bus.seg), 32'(7'h7F));
    chk("rst_dp", 32'(bus.dp), 32'(1'b1));
    chk("rst_fd", 32'(bus.frame_done), 32'(1'b0));
    chk("rst_idx", 32'(bus.digit_idx), 32'(2'd0));
    reset = 1'b0;
    clear_stats();
  endtask

  // Edge-parameter instance: no blanking, idx steps every 2 cycles, one anode max.
  initial begin : edge_mon
    int   k2;
    logic r;
    k2 = 0;
    forever begin
      @(posedge clk);
      r = reset2;
      @(negedge clk);
      if (r === 1'b1) k2 = 0;
      else if (r === 1'b0) begin
        k2++;
        chk("edge_idx", 32'(bus2.digit_idx), 32'((k2 / 2) % 4));
        chk("edge_onehot", 32'($countones(~bus2.an) <= 1), 32'(1'b1));
        if (k2 >= 2) chk("edge_noblank", 32'(bus2.an != 4'hF), 32'(1'b1));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    reset          = 1'b1;
    reset2         = 1'b1;
    bus.digits     = 16'h4321;
    bus.dp_in      = 4'h0;
    bus.digit_en   = 4'hF;
    bus.brightness = 3'd7;
    bus2.digits     = 16'h4321;
    bus2.dp_in      = 4'h0;
    bus2.digit_en   = 4'hF;
    bus2.brightness = 3'd7;
    clear_stats();

    // Basic scan
    do_reset(2);
    reset2 = 1'b0;
    repeat (64) cyc();
    chk("basic_lit0", 32'(lit_cnt[0]), 32'd12);
    chk("basic_lit1", 32'(lit_cnt[1]), 32'd12);
    chk("basic_lit2", 32'(lit_cnt[2]), 32'd12);
    chk("basic_lit3", 32'(lit_cnt[3]), 32'd12);
    chk("basic_seg0", 32'(seg_seen[0]), 32'h79);
    chk("basic_seg1", 32'(seg_seen[1]), 32'h24);
    chk("basic_seg2", 32'(seg_seen[2]), 32'h30);
    chk("basic_seg3", 32'(seg_seen[3]), 32'h19);
    chk("basic_fd_at", 32'(fd_at), 32'd64);
    repeat (64) cyc();
    chk("basic_fd_cnt", 32'(fd_cnt), 32'd2);
    chk("basic_onehot", 32'(multi_an), 32'd0);

    // Disabled digits and decimal points
    bus.digit_en = 4'b1010;
    bus.dp_in    = 4'b0010;
    do_reset(1);
    repeat (64) cyc();
    chk("dis_lit0", 32'(lit_cnt[0]), 32'd0);
    chk("dis_lit1", 32'(lit_cnt[1]), 32'd12);
    chk("dis_lit2", 32'(lit_cnt[2]), 32'd0);
    chk("dis_lit3", 32'(lit_cnt[3]), 32'd12);
    chk("dis_dp1", 32'(dp_low[1]), 32'd12);
    chk("dis_dp3", 32'(dp_low[3]), 32'd0);
    chk("dis_fd_at", 32'(fd_at), 32'd64);

    // Mid-slot digit change
    bus.digit_en = 4'hF;
    bus.dp_in    = 4'h0;
    bus.digits   = 16'h4321;
    do_reset(1);
    repeat (8) cyc();
    bus.digits = 16'h8765;
    repeat (56) cyc();
    chk("mid_seg0", 32'(seg_seen[0]), 32'h79);
    chk("mid_seg1", 32'(seg_seen[1]), 32'h02);
    chk("mid_seg2", 32'(seg_seen[2]), 32'h78);
    chk("mid_seg3", 32'(seg_seen[3]), 32'h00);

    // PWM brightness 1 then 0
    bus.digits     = 16'h4321;
    bus.brightness = 3'd1;
    do_reset(1);
    repeat (64) cyc();
    for (int i = 0; i < 4; i++) chk("pwm1_lit", 32'(lit_cnt[i]), 32'd2);
    bus.brightness = 3'd0;
    do_reset(1);
    repeat (64) cyc();
    for (int i = 0; i < 4; i++) chk("pwm0_lit", 32'(lit_cnt[i]), 32'd1);

    // Reset mid-frame at digit 2, slot count 9
    bus.brightness = 3'd7;
    do_reset(1);
    repeat (41) cyc();
    chk("midrst_pre_idx", 32'(bus.digit_idx), 32'd2);
    do_reset(1);
    repeat (63) cyc();
    chk("midrst_no_fd", 32'(fd_cnt), 32'd0);
    cyc();
    chk("midrst_fd", 32'(bus.frame_done), 32'(1'b1));
    chk("midrst_onehot", 32'(multi_an), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
